// File: rtl/serial_arith_pkg.sv
// Shared definitions for the word-framed bit-serial arithmetic unit.
//
// Contents:
//   MODE_PASS/ONES/TWOS/INC  2-bit operation codes, latched on the first bit of a word
//   state_e                  framing FSM encoding (ST_IDLE, ST_RUN)
//   mode_inv()               1 when the mode inverts each incoming bit
//   mode_carry_init()        carry value loaded on the first bit of a word
package serial_arith_pkg;

   localparam logic [1:0] MODE_PASS = 2'd0;
   localparam logic [1:0] MODE_ONES = 2'd1;
   localparam logic [1:0] MODE_TWOS = 2'd2;
   localparam logic [1:0] MODE_INC  = 2'd3;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   // ONES and TWOS both start from the inverted operand.
   function automatic logic mode_inv(input logic [1:0] m);
      return (m == MODE_ONES) || (m == MODE_TWOS);
   endfunction

   // TWOS is ~x + 1 and INC is x + 1; both inject the +1 as the initial carry.
   function automatic logic mode_carry_init(input logic [1:0] m);
      return (m == MODE_TWOS) || (m == MODE_INC);
   endfunction

endpackage

// File: rtl/serial_bit_cell.sv
// One bit slice of the serial adder: optionally inverts the operand bit and
// adds the running carry (the second addend is always zero).
//
// Ports:
//   in_bit     operand bit
//   inv        invert the operand bit before the add
//   carry      carry into this bit position
//   out_bit    result bit
//   carry_out  carry into the next bit position
module serial_bit_cell (
   input  logic in_bit,
   input  logic inv,
   input  logic carry,
   output logic out_bit,
   output logic carry_out
);

   logic t;

   always_comb begin
      t         = in_bit ^ inv;
      out_bit   = t ^ carry;
      carry_out = t & carry;
   end

endmodule

// File: rtl/serial_complementer_word.sv
// Word-framed, LSB-first bit-serial arithmetic unit. Each word of WIDTH bits is
// passed through, ones' complemented, negated or incremented according to the
// mode latched with its first bit. Results leave through a single registered
// output stage with a valid/ready handshake and one cycle of latency.
//
// Ports:
//   clk        clock, rising edge
//   areset     asynchronous reset, active-high
//   mode       operation select, sampled only on an accepted first bit
//   in_valid   in_bit/in_first valid
//   in_ready   unit can accept a bit this cycle
//   in_bit     serial operand, LSB first
//   in_first   marks the LSB of a word
//   out_valid  out_bit valid
//   out_ready  consumer accepts out_bit
//   out_bit    serial result, LSB first
//   out_first  result LSB marker
//   out_last   result MSB marker
//   out_ovf    signed overflow of the word, meaningful only with out_last
//   sync_err   one-cycle pulse when a word restarts before it completed
module serial_complementer_word
   import serial_arith_pkg::*;
#(
   parameter  int unsigned WIDTH = 8,
   localparam int unsigned CNT_W = $clog2(WIDTH)
) (
   input  logic       clk,
   input  logic       areset,
   input  logic [1:0] mode,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic       in_bit,
   input  logic       in_first,
   output logic       out_valid,
   input  logic       out_ready,
   output logic       out_bit,
   output logic       out_first,
   output logic       out_last,
   output logic       out_ovf,
   output logic       sync_err
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   // Framing and datapath state
   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             carry_q, carry_d;
   logic [1:0]       mode_q, mode_d;

   // Output register
   logic             out_valid_q, out_valid_d;
   logic             out_bit_q, out_bit_d;
   logic             out_first_q, out_first_d;
   logic             out_last_q, out_last_d;
   logic             out_ovf_q, out_ovf_d;
   logic             sync_err_q, sync_err_d;

   // Per-bit effective operands
   logic             accept;
   logic             start;
   logic             work;
   logic [1:0]       mode_eff;
   logic             carry_eff;
   logic [CNT_W-1:0] cnt_eff;
   logic             is_last;
   logic             cell_bit;
   logic             cell_carry;

   // The single output register may be refilled in the same cycle it drains.
   assign in_ready = out_ready | ~out_valid_q;
   assign accept   = in_valid & in_ready;

   // A first bit always opens a fresh word, whatever state we are in; any other
   // bit only counts while a word is open.
   assign start     = accept & in_first;
   assign work      = start | (accept & (state_q == ST_RUN));
   assign mode_eff  = start ? mode : mode_q;
   assign carry_eff = start ? mode_carry_init(mode) : carry_q;
   assign cnt_eff   = start ? '0 : cnt_q;
   assign is_last   = (cnt_eff == CNT_LAST);

   serial_bit_cell u_cell (
      .in_bit    (in_bit),
      .inv       (mode_inv(mode_eff)),
      .carry     (carry_eff),
      .out_bit   (cell_bit),
      .carry_out (cell_carry)
   );

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      carry_d     = carry_q;
      mode_d      = mode_q;
      out_valid_d = out_valid_q;
      out_bit_d   = out_bit_q;
      out_first_d = out_first_q;
      out_last_d  = out_last_q;
      out_ovf_d   = out_ovf_q;

      // Aborting an open word: RUN always holds a non-zero count, the check on
      // the counter just keeps the condition self-evident.
      sync_err_d = start && (state_q == ST_RUN) && (cnt_q != '0);

      if (out_ready) begin
         out_valid_d = 1'b0;
      end

      if (work) begin
         out_valid_d = 1'b1;
         out_bit_d   = cell_bit;
         out_first_d = start;
         out_last_d  = is_last;
         // Signed overflow: carry into the MSB differs from carry out of it.
         out_ovf_d   = is_last & (carry_eff ^ cell_carry);
         mode_d      = mode_eff;
         if (is_last) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            carry_d = 1'b0;
         end else begin
            state_d = ST_RUN;
            cnt_d   = cnt_eff + CNT_W'(1);
            carry_d = cell_carry;
         end
      end
   end

   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         carry_q     <= 1'b0;
         mode_q      <= MODE_PASS;
         out_valid_q <= 1'b0;
         out_bit_q   <= 1'b0;
         out_first_q <= 1'b0;
         out_last_q  <= 1'b0;
         out_ovf_q   <= 1'b0;
         sync_err_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         carry_q     <= carry_d;
         mode_q      <= mode_d;
         out_valid_q <= out_valid_d;
         out_bit_q   <= out_bit_d;
         out_first_q <= out_first_d;
         out_last_q  <= out_last_d;
         out_ovf_q   <= out_ovf_d;
         sync_err_q  <= sync_err_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_bit   = out_bit_q;
   assign out_first = out_first_q;
   assign out_last  = out_last_q;
   assign out_ovf   = out_ovf_q;
   assign sync_err  = sync_err_q;

endmodule

// File: doc/serial_complementer_word.md
Name: serial_complementer_word

Overview:
- Parametrised, word-framed, LSB-first bit-serial arithmetic unit; successor to the single-mode serial two's complementer FSM.
- Supports four modes: pass, ones' complement, two's complement (negate), increment. Mode is latched per word.
- Adds word framing (bit counter, first/last markers), signed-overflow detection, a valid/ready handshake and a registered output stage.
- Sits between a bit-serial source (deserialiser or serial ALU stage) and a bit-serial consumer.

Parameters:
- WIDTH, 8, word length in bits; legal range WIDTH >= 2.
- CNT_W, $clog2(WIDTH), bit-counter width; derived, not overridden.

Ports:
- clk  input  1  clock, rising edge
- areset  input  1  asynchronous reset, active-high
- mode  input  2  0=PASS, 1=ONES, 2=TWOS, 3=INC; sampled only on an accepted first bit
- in_valid  input  1  in_bit/in_first valid
- in_ready  output  1  unit can accept a bit this cycle
- in_bit  input  1  serial data, LSB first
- in_first  input  1  marks the LSB of a word
- out_valid  output  1  out_bit valid
- out_ready  input  1  consumer accepts out_bit
- out_bit  output  1  result bit, LSB first
- out_first  output  1  result LSB marker
- out_last  output  1  result MSB marker
- out_ovf  output  1  signed overflow of the word; meaningful only with out_last
- sync_err  output  1  one-cycle pulse: word restarted before completion

Behaviour:
- Reset: areset is asynchronous, active-high; clock is clk. On reset: state=IDLE, counter=0, carry=0, latched mode=PASS, out_valid=0, out_bit=0, out_first=0, out_last=0, out_ovf=0, sync_err=0. Reset mid-word discards the partial word; no output is produced for it.
- Handshake: accept = in_valid & in_ready. in_ready = out_ready | ~out_valid (single output register). Output fields hold stable while out_valid & ~out_ready.
- Latency: an accepted bit appears on out_bit on the next clk edge, i.e. one-cycle latency. Back-to-back words are allowed with zero gap.
- States:
  - IDLE: accepted bits with in_first=0 are consumed and dropped; no output, no sync_err. An accepted bit with in_first=1 latches mode, loads the carry, processes the bit with count=0, then goes to RUN (or stays IDLE if WIDTH reached, not possible since WIDTH >= 2).
  - RUN: each accepted bit is processed and the counter increments. The bit with count=WIDTH-1 is the MSB: out_last=1, then back to IDLE.
  - RUN with an accepted in_first=1 and count != 0: sync_err pulses on the next cycle; the partial word is abandoned (no out_last, ovf not reported); the bit starts a new word as in IDLE.
- Datapath per bit:
  - inv = (mode==ONES | mode==TWOS); carry loads 1 for TWOS/INC and 0 for PASS/ONES on the first bit.
  - t = in_bit ^ inv; out_bit = t ^ carry; carry_next = t & carry.
  - TWOS reproduces the original behaviour: copy bits through the first 1, invert after it.
- Overflow: at the MSB, out_ovf = carry_in ^ carry_out. This is always 0 for PASS/ONES. It is 1 for TWOS of the most-negative value (1000..0) and for INC of the most-positive value (0111..1). INC of all-ones wraps to 0 with out_ovf=0.
- Mode changes mid-word are ignored until the next in_first.
- sync_err is independent of out_ready and is never stalled.

Decomposition:
- Package serial_arith_pkg:
  - mode localparams MODE_PASS/ONES/TWOS/INC (2-bit);
  - FSM state encoding ST_IDLE/ST_RUN.
- One combinational sub-module serial_bit_cell: inputs bit, inv, carry; outputs out_bit, carry_out. The top level holds the FSM, counter, carry register, handshake and output register.

Test Plan (WIDTH=4, bits listed LSB first):
1. TWOS, in 0,1,1,0 (+6), out_ready=1 -> out 0,1,0,1 (-6); out_first on bit0, out_last on bit3, out_ovf=0.
2. TWOS, in 0,0,0,1 (-8) -> out 0,0,0,1; out_ovf=1 with out_last. Then TWOS of 0,0,0,0 -> 0,0,0,0 with ovf=0, issued back-to-back with no gap.
3. INC, in 1,1,1,0 (+7) -> 0,0,0,1, ovf=1. INC, in 1,1,1,1 -> 0,0,0,0, ovf=0. ONES, in 1,0,1,0 -> 0,1,0,1, ovf=0. PASS is identity.
4. Backpressure: drop out_ready for 3 cycles after bit1 of a TWOS word -> in_ready=0 during the stall, out_bit/out_first/out_last hold stable, and the full word is correct with no bit lost or duplicated.
5. Resync: in_first reasserted at count=2 -> sync_err=1 for exactly one cycle; no out_last for the aborted word; the new word's result is correct. Bits before the first in_first after reset produce no output.
6. areset asserted asynchronously mid-word (between edges) -> all outputs 0 immediately; the next word with in_first is processed correctly from count 0.
